// File: rtl/lsu_unit.sv
// ============================================================================
// Module      : lsu_unit
// Description : Load/store unit running one req/gnt/rvalid data-bus
//               transaction per request. Load data is aligned and extended
//               before it goes back to the register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // issue-stage request
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [1:0]        data_type_i,
    input  logic              data_sext_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [31:0]       lsu_wdata_i,
    input  logic [4:0]        rf_waddr_i,
    output logic              busy_o,
    // data-memory bus
    output logic              data_req_o,
    input  logic              data_gnt_i,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [31:0]       data_wdata_o,
    input  logic              data_rvalid_i,
    input  logic [31:0]       data_rdata_i,
    input  logic              data_err_i,
    // register-file write-back and completion
    output logic              rf_we_o,
    output logic [4:0]        rf_waddr_o,
    output logic [31:0]       rf_wdata_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_RESP = 2'd3;

    localparam logic [1:0] c_TYPE_WORD = 2'b00;
    localparam logic [1:0] c_TYPE_HALF = 2'b01;
    localparam logic [1:0] c_TYPE_BYTE = 2'b10;

    logic [1:0]        r_state;
    logic              r_we;
    logic [1:0]        r_type;
    logic              r_sext;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [4:0]        r_waddr;
    logic              r_err;
    logic [31:0]       r_rdata;

    logic              w_bad;
    logic [1:0]        w_off;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_shift;
    logic [31:0]       w_load;
    logic              w_in_req;
    logic              w_in_resp;
    logic              w_rf_we;

    // Alignment / legality of the incoming request, judged on the live inputs
    always_comb begin
        w_bad = 1'b0;
        case (data_type_i)
            c_TYPE_WORD: w_bad = |lsu_addr_i[1:0];
            c_TYPE_HALF: w_bad = lsu_addr_i[0];
            c_TYPE_BYTE: w_bad = 1'b0;
            default:     w_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
            r_we    <= 1'b0;
            r_type  <= 2'b00;
            r_sext  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_waddr <= 5'd0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (data_req_i) begin
                        r_we    <= data_we_i;
                        r_type  <= data_type_i;
                        r_sext  <= data_sext_i;
                        r_addr  <= lsu_addr_i;
                        r_wdata <= lsu_wdata_i;
                        r_waddr <= rf_waddr_i;
                        r_err   <= w_bad;
                        r_rdata <= 32'd0;
                        r_state <= w_bad ? c_ST_RESP : c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    // A response in the grant cycle is a protocol violation; only the grant matters here
                    if (data_gnt_i) begin
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (data_rvalid_i) begin
                        r_rdata <= data_rdata_i;
                        r_err   <= data_err_i;
                        r_state <= c_ST_RESP;
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign w_off = r_addr[1:0];

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
        case (r_type)
            c_TYPE_BYTE: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{r_wdata[7:0]}};
            end
            c_TYPE_HALF: begin
                w_be    = 4'b0011 << w_off;
                w_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_wdata;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend to the access size
    assign w_shift = r_rdata >> {w_off, 3'b000};

    always_comb begin
        w_load = w_shift;
        case (r_type)
            c_TYPE_BYTE: w_load = {{24{r_sext & w_shift[7]}}, w_shift[7:0]};
            c_TYPE_HALF: w_load = {{16{r_sext & w_shift[15]}}, w_shift[15:0]};
            default:     w_load = w_shift;
        endcase
    end

    assign w_in_req  = (r_state == c_ST_REQ);
    assign w_in_resp = (r_state == c_ST_RESP);
    assign w_rf_we   = w_in_resp & ~r_we & ~r_err;

    assign busy_o       = (r_state != c_ST_IDLE);
    assign data_req_o   = w_in_req;
    assign data_addr_o  = w_in_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign data_we_o    = w_in_req & r_we;
    assign data_be_o    = w_in_req ? w_be : 4'b0000;
    assign data_wdata_o = (w_in_req && r_we) ? w_wdata : 32'd0;

    assign done_o     = w_in_resp;
    assign err_o      = w_in_resp & r_err;
    assign rf_we_o    = w_rf_we;
    assign rf_waddr_o = w_rf_we ? r_waddr : 5'd0;
    assign rf_wdata_o = w_rf_we ? w_load : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_lsu_unit.sv
// ============================================================================
// Module      : tb_lsu_unit
// Description : Self-checking bench for lsu_unit: directed scenarios plus
//               randomized transactions against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req_i;
    logic        data_we_i;
    logic [1:0]  data_type_i;
    logic        data_sext_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic [4:0]  rf_waddr_i;
    logic        busy_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        done_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_unit #(.ADDR_W(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_req_i   (data_req_i),
        .data_we_i    (data_we_i),
        .data_type_i  (data_type_i),
        .data_sext_i  (data_sext_i),
        .lsu_addr_i   (lsu_addr_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .rf_waddr_i   (rf_waddr_i),
        .busy_o       (busy_o),
        .data_req_o   (data_req_o),
        .data_gnt_i   (data_gnt_i),
        .data_addr_o  (data_addr_o),
        .data_we_o    (data_we_o),
        .data_be_o    (data_be_o),
        .data_wdata_o (data_wdata_o),
        .data_rvalid_i(data_rvalid_i),
        .data_rdata_i (data_rdata_i),
        .data_err_i   (data_err_i),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_req"},  32'(data_req_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_err"},  32'(err_o), 32'd0);
        check({tag, "_rfwe"}, 32'(rf_we_o), 32'd0);
        check({tag, "_rfd"},  rf_wdata_o, 32'd0);
        check({tag, "_be"},   32'(data_be_o), 32'd0);
    endtask

    // One complete transaction; outputs are checked at every negedge.
    task automatic run_txn(input logic we, input logic [1:0] ty, input logic sx,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wa,
                           input int gw, input int rw, input logic [31:0] rd,
                           input logic berr, input logic poke);
        logic        bad;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] eres;
        longint      v;
        int          off;
        off  = int'(addr % 4);
        bad  = (ty == 2'd3) || (ty == 2'd0 && off != 0) || (ty == 2'd1 && off % 2 != 0);
        ebe  = (ty == 2'd2) ? 4'(1 << off) : (ty == 2'd1) ? 4'(3 << off) : 4'hF;
        if (!we)             ewd = 32'd0;
        else if (ty == 2'd2) ewd = (wd % 256) * 32'h0101_0101;
        else if (ty == 2'd1) ewd = (wd % 65536) * 32'h0001_0001;
        else                 ewd = wd;
        if (ty == 2'd2) begin
            v = longint'((rd >> (8 * off)) % 256);
            if (sx && v >= 128) v = v - 256;
        end else if (ty == 2'd1) begin
            v = longint'((rd >> (8 * off)) % 65536);
            if (sx && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(rd);
        end
        eres = v[31:0];

        @(negedge clk);
        check("idle_busy", 32'(busy_o), 32'd0);
        check("idle_req", 32'(data_req_o), 32'd0);
        data_req_i  = 1'b1;
        data_we_i   = we;
        data_type_i = ty;
        data_sext_i = sx;
        lsu_addr_i  = addr;
        lsu_wdata_i = wd;
        rf_waddr_i  = wa;
        @(negedge clk);
        data_req_i  = 1'b0;
        lsu_addr_i  = $urandom;
        lsu_wdata_i = $urandom;
        rf_waddr_i  = 5'($urandom);
        if (bad) begin
            check("bad_req", 32'(data_req_o), 32'd0);
            check("bad_done", 32'(done_o), 32'd1);
            check("bad_err", 32'(err_o), 32'd1);
            check("bad_rfwe", 32'(rf_we_o), 32'd0);
        end else begin
            for (int g = 0; g <= gw; g++) begin
                check("req_req", 32'(data_req_o), 32'd1);
                check("req_addr", data_addr_o, addr & 32'hFFFF_FFFC);
                check("req_we", 32'(data_we_o), 32'(we));
                check("req_be", 32'(data_be_o), 32'(ebe));
                check("req_wdata", data_wdata_o, ewd);
                check("req_done", 32'(done_o), 32'd0);
                data_gnt_i = (g == gw);
                if (poke && g == 0) begin
                    data_req_i  = 1'b1;
                    data_type_i = 2'd3;
                end
                @(negedge clk);
                data_gnt_i = 1'b0;
                data_req_i = 1'b0;
            end
            for (int r = 0; r <= rw; r++) begin
                check("wait_req", 32'(data_req_o), 32'd0);
                check("wait_busy", 32'(busy_o), 32'd1);
                check("wait_done", 32'(done_o), 32'd0);
                data_rvalid_i = (r == rw);
                data_rdata_i  = (r == rw) ? rd : $urandom;
                data_err_i    = berr && (r == rw);
                @(negedge clk);
                data_rvalid_i = 1'b0;
                data_err_i    = 1'b0;
            end
            check("resp_done", 32'(done_o), 32'd1);
            check("resp_err", 32'(err_o), 32'(berr));
            check("resp_rfwe", 32'(rf_we_o), 32'(!we && !berr));
            check("resp_rfd", rf_wdata_o, (!we && !berr) ? eres : 32'd0);
            check("resp_rfa", 32'(rf_waddr_o), (!we && !berr) ? 32'(wa) : 32'd0);
        end
        @(negedge clk);
        check("post_done", 32'(done_o), 32'd0);
        check("post_busy", 32'(busy_o), 32'd0);
        check("post_rfwe", 32'(rf_we_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        data_req_i = 1'b0; data_we_i = 1'b0; data_type_i = 2'd0; data_sext_i = 1'b0;
        lsu_addr_i = 32'd0; lsu_wdata_i = 32'd0; rf_waddr_i = 5'd0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'd0; data_err_i = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;

        // signed byte load, top lane
        run_txn(1'b0, 2'b10, 1'b1, 32'h0000_1003, 32'd0, 5'd7, 0, 0, 32'h80FF_0000, 1'b0, 1'b0);
        // half store with grant held off three cycles
        run_txn(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 5'd3, 3, 0, 32'd0, 1'b0, 1'b0);
        // misaligned word and reserved type
        run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0006, 32'd0, 5'd9, 0, 0, 32'd0, 1'b0, 1'b0);
        run_txn(1'b0, 2'b11, 1'b0, 32'h0000_0008, 32'd0, 5'd9, 0, 0, 32'd0, 1'b0, 1'b0);
        // bus error on a word load
        run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0040, 32'd0, 5'd4, 0, 1, 32'h1111_2222, 1'b1, 1'b0);

        // reset while waiting for the response, then a stray rvalid
        @(negedge clk);
        data_req_i = 1'b1; data_we_i = 1'b0; data_type_i = 2'd0; lsu_addr_i = 32'h80; rf_waddr_i = 5'd5;
        @(negedge clk);
        data_req_i = 1'b0; data_gnt_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0;
        check("rstw_busy", 32'(busy_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_AAAA;
        check_quiet("rstw_a");
        @(negedge clk);
        data_rvalid_i = 1'b0;
        check_quiet("rstw_b");
        run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'd0, 5'd12, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // request pulsed while busy must be ignored
        run_txn(1'b0, 2'b01, 1'b1, 32'h0000_0302, 32'd0, 5'd20, 1, 1, 32'h8001_7FFF, 1'b0, 1'b1);
        @(negedge clk);
        check("poke_extra_done", 32'(done_o), 32'd0);

        for (int i = 0; i < 60; i++) begin
            run_txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom,
                    ($urandom_range(0, 7) == 0), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
